// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared flit type and credit-width helper for the NoC link
package noc_pkg;

    localparam int FLIT_W = 64;

    typedef logic [FLIT_W-1:0] flit_t;

    // Counter width able to hold 0..n inclusive; the receiver sizes its
    // occupancy counter with the same function so both ends agree.
    function automatic int credit_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/noc_skid_buf.sv
// rtl/noc_skid_buf.sv - 2-entry FIFO holding flits that could not launch on arrival
module noc_skid_buf
    import noc_pkg::*;
#(
    parameter int WIDTH = FLIT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Payload storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/noc_credit_tx.sv
// rtl/noc_credit_tx.sv - credit-based link transmitter with skid buffer and registered launch
module noc_credit_tx
    import noc_pkg::*;
#(
    parameter  int DATA_WIDTH = FLIT_W,
    parameter  int CREDITS    = 4,
    localparam int CNT_W      = credit_w(CREDITS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  credit_in,
    output logic [CNT_W-1:0]      credits_avail,
    output logic                  idle,
    output logic                  credit_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]            skid_count;
    logic [DATA_WIDTH-1:0] skid_head;
    logic [CNT_W-1:0]      credit_cnt;
    logic                  skid_empty;
    logic                  accept;
    logic                  src_valid;
    logic [DATA_WIDTH-1:0] src_data;
    logic                  send;
    logic                  push;
    logic                  pop;

    assign skid_empty = (skid_count == 2'd0);
    assign in_ready   = !rst && (skid_count != 2'd2);
    assign accept     = in_valid && in_ready;

    // The skid head always goes first so flits leave in arrival order.
    assign src_valid  = !skid_empty || accept;
    assign src_data   = skid_empty ? in_data : skid_head;
    assign send       = src_valid && (credit_cnt != '0);
    assign pop        = send && !skid_empty;
    assign push       = accept && !(send && skid_empty);

    noc_skid_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (in_data),
        .pop       (pop),
        .head      (skid_head),
        .count     (skid_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            credit_cnt <= CNT_MAX;
            credit_err <= 1'b0;
        end else begin
            out_valid <= send;
            if (send) out_data <= src_data;
            // A returned credit with the counter already full means the
            // receiver freed a slot we never filled: saturate and flag it.
            case ({send, credit_in})
                2'b10: credit_cnt <= credit_cnt - CNT_ONE;
                2'b01: begin
                    if (credit_cnt == CNT_MAX) credit_err <= 1'b1;
                    else                       credit_cnt <= credit_cnt + CNT_ONE;
                end
                default: ;
            endcase
        end
    end

    assign credits_avail = credit_cnt;
    assign idle          = skid_empty && (credit_cnt == CNT_MAX);

endmodule

// File: tb/tb_noc_credit_tx.sv
// tb/tb_noc_credit_tx.sv - self-checking bench for noc_credit_tx
module tb_noc_credit_tx;
    import noc_pkg::*;

    localparam int DW = 64;
    localparam int CR = 4;
    localparam int CW = 3;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;
    localparam int N_FLITS = 10000;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          credit_in;
    logic [CW-1:0] credits_avail;
    logic          idle;
    logic          credit_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    noc_credit_tx #(.DATA_WIDTH(DW), .CREDITS(CR)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .credit_in     (credit_in),
        .credits_avail (credits_avail),
        .idle          (idle),
        .credit_err    (credit_err)
    );

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          cr;
        logic          rdy;
        logic          ov;
        logic [DW-1:0] od;
        logic [CW-1:0] cnt;
        logic          idl;
        logic          err;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [DW-1:0] d, input logic cr, input logic rdy,
                       input logic ov, input logic [DW-1:0] od, input logic [CW-1:0] cnt,
                       input logic idl, input logic err);
        vec_t v;
        v.iv = iv; v.d = d; v.cr = cr; v.rdy = rdy; v.ov = ov;
        v.od = od; v.cnt = cnt; v.idl = idl; v.err = err;
        vq.push_back(v);
    endtask

    task automatic cyc(input logic iv, input logic [DW-1:0] d, input logic cr);
        in_valid = iv; in_data = d; credit_in = cr;
        @(posedge clk); #1;
    endtask

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] rx_q[$];

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_valid", 64'(out_valid), 64'd0);
        chk("rst out_data", out_data, 64'd0);
        chk("rst credits", 64'(credits_avail), 64'd4);
        chk("rst idle", 64'(idle), 64'd1);
        chk("rst credit_err", 64'(credit_err), 64'd0);
        chk("rst in_ready", 64'(in_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("release in_ready", 64'(in_ready), 64'd1);

        // iv, data, credit_in | in_ready(pre-edge), out_valid, out_data, credits, idle, err
        add(H, 'hA0, L, H, H, 'hA0, 3, L, L);
        add(H, 'hA1, L, H, H, 'hA1, 2, L, L);
        add(H, 'hA2, L, H, H, 'hA2, 1, L, L);
        add(H, 'hA3, L, H, H, 'hA3, 0, L, L);
        add(H, 'hA4, L, H, L, 'hA3, 0, L, L);
        add(H, 'hB0, L, H, L, 'hA3, 0, L, L);
        add(H, 'hB1, L, L, L, 'hA3, 0, L, L);
        add(H, 'hB1, H, L, L, 'hA3, 1, L, L);
        add(H, 'hB1, L, L, H, 'hA4, 0, L, L);
        add(H, 'hB1, L, H, L, 'hA4, 0, L, L);
        add(L, 'h00, H, L, L, 'hA4, 1, L, L);
        add(L, 'h00, H, L, H, 'hB0, 1, L, L);
        add(L, 'h00, L, H, H, 'hB1, 0, L, L);
        add(L, 'h00, H, H, L, 'hB1, 1, L, L);
        add(L, 'h00, H, H, L, 'hB1, 2, L, L);
        add(L, 'h00, H, H, L, 'hB1, 3, L, L);
        add(L, 'h00, H, H, L, 'hB1, 4, H, L);
        add(H, 'hC0, L, H, H, 'hC0, 3, L, L);
        add(H, 'hC1, L, H, H, 'hC1, 2, L, L);
        add(H, 'hC2, H, H, H, 'hC2, 2, L, L);
        add(L, 'h00, H, H, L, 'hC2, 3, L, L);
        add(L, 'h00, H, H, L, 'hC2, 4, H, L);
        add(L, 'h00, H, H, L, 'hC2, 4, H, H);
        add(H, 'hD0, L, H, H, 'hD0, 3, L, H);
        add(L, 'h00, H, H, L, 'hD0, 4, H, H);

        for (int i = 0; i < vq.size(); i++) begin
            in_valid = vq[i].iv; in_data = vq[i].d; credit_in = vq[i].cr;
            #1;
            chk($sformatf("v%0d in_ready", i), 64'(in_ready), 64'(vq[i].rdy));
            @(posedge clk); #1;
            chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'(vq[i].ov));
            chk($sformatf("v%0d out_data", i), out_data, vq[i].od);
            chk($sformatf("v%0d credits", i), 64'(credits_avail), 64'(vq[i].cnt));
            chk($sformatf("v%0d idle", i), 64'(idle), 64'(vq[i].idl));
            chk($sformatf("v%0d credit_err", i), 64'(credit_err), 64'(vq[i].err));
        end

        // Reset mid-operation with a flit in flight and one still in the skid.
        cyc(H, 'hE0, L); cyc(H, 'hE1, L); cyc(H, 'hE2, L); cyc(H, 'hE3, L);
        cyc(H, 'hE4, L); cyc(H, 'hE5, L);
        chk("pre-rst skid full", 64'(in_ready), 64'd0);
        cyc(L, 'h00, H);
        cyc(L, 'h00, L);
        chk("pre-rst out_valid", 64'(out_valid), 64'd1);
        chk("pre-rst out_data", out_data, 64'hE4);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(out_valid), 64'd0);
        chk("async rst out_data", out_data, 64'd0);
        chk("async rst credits", 64'(credits_avail), 64'd4);
        chk("async rst credit_err", 64'(credit_err), 64'd0);
        chk("async rst idle", 64'(idle), 64'd1);
        chk("async rst in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(L, 'h00, L);
            chk($sformatf("post-rst stale %0d", i), 64'(out_valid), 64'd0);
            chk($sformatf("post-rst idle %0d", i), 64'(idle), 64'd1);
        end
        cyc(H, 'hF0, L);
        chk("post-rst first flit", out_data, 64'hF0);
        chk("post-rst first valid", 64'(out_valid), 64'd1);
        cyc(L, 'h00, H);
        chk("post-rst credits", 64'(credits_avail), 64'd4);

        // Random traffic into a 4-deep receiver model with random drain.
        begin
            int sent = 0;
            int recv = 0;
            int cycles = 0;
            logic drain;
            while (recv < N_FLITS && cycles < 60000) begin
                cycles++;
                in_valid = (sent < N_FLITS) && ($urandom_range(0, 9) < 7);
                in_data = 64'hC0DE_0000_0000_0000 ^ 64'(sent);
                drain = (rx_q.size() > 0) && ($urandom_range(0, 3) != 0);
                credit_in = drain;
                #1;
                chk("rand in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_data);
                    sent++;
                end
                if (drain) begin
                    void'(rx_q.pop_front());
                    recv++;
                end
                @(posedge clk); #1;
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("rand spurious flit", 64'(out_valid), 64'd0);
                    end else begin
                        chk("rand order", out_data, exp_q.pop_front());
                    end
                    rx_q.push_back(out_data);
                    if (rx_q.size() > CR) chk("rand rx overflow", 64'(rx_q.size()), 64'(CR));
                end
                chk("rand credit track", 64'(int'(credits_avail) + rx_q.size()), 64'(CR));
            end
            in_valid = 1'b0; credit_in = 1'b0;
            chk("rand delivered", 64'(recv), 64'(N_FLITS));
            @(posedge clk); #1;
            chk("rand credit_err", 64'(credit_err), 64'd0);
            chk("rand final idle", 64'(idle), 64'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
